// File: rtl/reg_dump_reader.sv
// Debug read-out engine: sweeps the register file read port and streams each byte over valid/ready.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last register.
module reg_dump_reader #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DATA_W   = 8
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_reg_num,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, READ, SEND, FINISH, CSUM} state_t;
   logic [DATA_W-1:0] csum;
`else
   typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} state_t;
`endif

   state_t            state;
   logic [ADDR_W-1:0] index;

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state      <= IDLE;
         index      <= '0;
         rd_reg_num <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         done <= 1'b0;
         // Abort cancels any active transfer state; FINISH is already past the point of no return.
         if (abort && state != IDLE && state != FINISH) begin
            state      <= IDLE;
            index      <= '0;
            rd_reg_num <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     index      <= '0;
                     rd_reg_num <= '0;
                     busy       <= 1'b1;
                     state      <= READ;
`ifdef REG_DUMP_CHECKSUM_EN
                     csum       <= '0;
`endif
                  end
               end
               READ: begin
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                  out_last  <= 1'b0;
`else
                  out_last  <= (index == LAST_IDX);
`endif
                  state     <= SEND;
               end
               SEND: begin
                  if (out_ready) begin
                     if (index == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Fold the final register byte in and present the checksum straight away.
                        out_data <= csum ^ out_data;
                        out_last <= 1'b1;
                        state    <= CSUM;
`else
                        out_valid <= 1'b0;
                        state     <= FINISH;
`endif
                     end else begin
                        index      <= index + ADDR_W'(1);
                        rd_reg_num <= index + ADDR_W'(1);
                        out_valid  <= 1'b0;
                        state      <= READ;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum       <= csum ^ out_data;
`endif
                     end
                  end
               end
`ifdef REG_DUMP_CHECKSUM_EN
               CSUM: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= FINISH;
                  end
               end
`endif
               FINISH: begin
                  done     <= 1'b1;
                  out_last <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: register file model, directed scenarios and randomized dumps.
module tb_reg_dump_reader;

   localparam int unsigned N = 8;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int unsigned CS = 1;
`else
   localparam int unsigned CS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort, out_ready;
   logic [2:0] rd_reg_num;
   logic [7:0] rd_data, out_data;
   logic       out_valid, out_last, busy, done;
   logic [7:0] regs [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rd_data = regs[rd_reg_num];

   reg_dump_reader #(.NUM_REGS(N), .ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .Reset(rst_n), .start(start), .abort(abort),
      .rd_reg_num(rd_reg_num), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_last"},  32'(out_last), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
   endtask

   // One full dump; rmode 0: ready always, 1: ready 1-of-3, 2: random ready.
   task automatic dump(input int rmode, input int restart_at, input string tag);
      logic [8:0] exp_q[$];
      logic [8:0] got_q[$];
      logic [7:0] x;
      logic [7:0] prev_data;
      logic       prev_last, prev_stall, rdy, restarted;
      int         cyc, dones;
      x = 8'h00;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back({(i == N - 1) && (CS == 0), regs[i]});
         x ^= regs[i];
      end
      if (CS != 0) exp_q.push_back({1'b1, x});
      cyc = 0; dones = 0; prev_stall = 0; restarted = 0;
      prev_data = '0; prev_last = 0;
      start = 1'b1;
      out_ready = 1'b0;
      while (cyc < 1000 && dones == 0) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (restart_at >= 0 && !restarted && got_q.size() == restart_at && out_valid) begin
            start = 1'b1;
            restarted = 1;
         end
         if (done) dones++;
         if (prev_stall) begin
            check({tag, "_stall_valid"}, 32'(out_valid), 1);
            check({tag, "_stall_data"},  32'(out_data), 32'(prev_data));
            check({tag, "_stall_last"},  32'(out_last), 32'(prev_last));
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (out_valid && rdy) got_q.push_back({out_last, out_data});
         prev_stall = out_valid && !rdy;
         prev_data  = out_data;
         prev_last  = out_last;
      end
      out_ready = 1'b0;
      check({tag, "_done_seen"}, 32'(dones), 1);
      if (rmode == 0) check({tag, "_latency"}, 32'(cyc), 32'(2 * N + 2 + CS));
      check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
   endtask

   // Accept bytes with ready=1 until `n` are taken and the next byte is waiting in SEND.
   task automatic advance_to_byte(input int n, input string tag);
      int taken, cyc;
      taken = 0; cyc = 0;
      start = 1'b1;
      out_ready = 1'b0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (out_valid && taken == n) break;
         out_ready = out_valid;
         if (out_valid) taken++;
      end
      out_ready = 1'b0;
      check({tag, "_reached"}, 32'(out_valid), 1);
   endtask

   initial begin
      int dones;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) regs[i] = 8'(i);
      repeat (3) @(negedge clk);
      check("rst_data", 32'(out_data), 0);
      check("rst_regnum", 32'(rd_reg_num), 0);
      check_idle_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      dump(0, -1, "plain");

      regs[3] = 8'hA5;
      dump(1, -1, "stall");

      dump(2, 4, "restart_busy");

      advance_to_byte(2, "abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_zero("abort");
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 0);
      dump(0, -1, "after_abort");

      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", 32'(busy), 0);

      advance_to_byte(5, "reset");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_mid_data", 32'(out_data), 0);
      check("reset_mid_regnum", 32'(rd_reg_num), 0);
      check_idle_zero("reset_mid");
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("reset_no_done", 32'(dones), 0);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) regs[i] = 8'($urandom);
         dump(2, -1, $sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug read-out engine for the 8x8-bit register file.
- On a start pulse it walks the register file's second read port from register 0 to NUM_REGS-1.
- It captures each value and streams it out as bytes over a valid/ready interface, e.g. toward a UART TX or a test bench monitor.
- It is the read-side counterpart of the writeback path and sits beside the register file, sharing its clock and reset.

Parameters:
- NUM_REGS, 8, number of registers swept; must be >= 1 and <= 2**ADDR_W.
- ADDR_W, 3, register number width.
- DATA_W, 8, register and stream data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous active-low reset, sampled on posedge clk.
- start  input  1  single-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  cancels a dump in progress.
- rd_reg_num  output  ADDR_W  register number driven to the register file read port.
- rd_data  input  DATA_W  combinational read data returned for rd_reg_num.
- out_data  output  DATA_W  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  marks the final byte of a dump; valid only with out_valid.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (Reset==0 at posedge), with priority over everything else:
  - state=IDLE, index=0.
  - rd_reg_num=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - The same applies mid-dump: the partial dump is discarded and done is not asserted.
- States: IDLE, READ, SEND, FINISH (plus CSUM under the optional feature). All outputs are registered.
- IDLE:
  - start=1 -> index=0, rd_reg_num=0, go to READ.
  - done is low in IDLE except for the single pulse cycle described under FINISH.
- READ (one cycle):
  - rd_reg_num is stable; out_data<=rd_data, out_valid<=1.
  - out_last<=(index==NUM_REGS-1) (without CHECKSUM_EN).
  - Go to SEND.
- SEND:
  - Hold out_data, out_valid and out_last stable until out_valid&&out_ready.
  - On that handshake, if index==NUM_REGS-1: out_valid<=0, go to FINISH.
  - Otherwise: index<=index+1, rd_reg_num<=index+1, out_valid<=0, go to READ.
- FINISH: done<=1 for exactly one cycle, out_last<=0, go to IDLE.
- Latency:
  - start sampled at edge E -> READ at E+1 -> out_valid high from E+2.
  - Minimum 2 cycles per byte with out_ready tied high, i.e. 2*NUM_REGS+2 cycles from start to done pulse.
- Snapshot semantics:
  - Each byte is the register value sampled during that register's READ cycle.
  - A writeback to a register not yet read is reflected in the dump; no atomic snapshot.
- start while busy: ignored, with no restart and no queuing.
- abort=1 in READ/SEND/CSUM:
  - Next state is IDLE; out_valid, out_last and index are cleared; no done pulse.
  - A byte presented in the same cycle as abort counts as accepted if out_ready=1, but the dump still ends without done.
  - abort has priority over start.
- Simultaneous start and abort in IDLE: abort wins; remain IDLE.
- out_ready high while out_valid is low has no effect.
- index wraps never: the sweep always terminates at NUM_REGS-1.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all transmitted register bytes, reset to 0 on start, is kept.
  - After the handshake of register NUM_REGS-1, go to CSUM instead of FINISH, with out_last=0 on register bytes.
  - CSUM presents out_data=checksum, out_valid=1, out_last=1.
  - On handshake go to FINISH.
  - Total bytes per dump: NUM_REGS+1.
- Not defined: no CSUM state, no accumulator logic; out_last is asserted on register NUM_REGS-1.

Test Plan:
- Reset, register file at reset values 0..7, out_ready=1, pulse start:
  - Bytes 00,01,...,07 in order, out_last only on 07.
  - done pulses once 18 cycles after start; busy low afterwards.
- Write reg3=0xA5, then dump with out_ready toggling 1-of-3 cycles:
  - Same order with 0xA5 in position 3.
  - out_data, out_valid and out_last stay stable while stalled; no byte duplicated or dropped.
- Pulse start again while busy during byte 4:
  - Dump continues unchanged, exactly 8 bytes, one done pulse.
- Assert abort while waiting in SEND on byte 2:
  - Next cycle out_valid=0, busy=0, no done.
  - A following start restarts from reg 0.
- Drive Reset low for one edge during byte 5:
  - All outputs 0, state IDLE, no done pulse.
- With REG_DUMP_CHECKSUM_EN and reg3=0xA5, others at reset values:
  - 9 bytes, final byte 0xA6 carrying out_last; byte 07 has out_last=0.
